// File: rtl/cdc_fifo_slice_unpacker.sv
// Receiver-domain unpacker behind the CDC FIFO: takes one peeked word, streams it
// out as Ratio slices (LS slice first) on a valid/ready interface, flagging the last.
module cdc_fifo_slice_unpacker #(
  parameter int DataWidth  = 32,
  parameter int SliceWidth = 8
) (
  input  logic                  clk_DB,
  input  logic                  rst_n,
  input  logic                  In_Valid_DB,
  input  logic [DataWidth-1:0]  In_Data_DB,
  output logic                  In_Deq_DB,
  output logic                  Out_Valid_DB,
  output logic [SliceWidth-1:0] Out_Data_DB,
  output logic                  Out_Last_DB,
  input  logic                  Out_Ready_DB,
  output logic                  Busy_DB
);

  localparam int Ratio    = DataWidth / SliceWidth;
  localparam int IdxWidth = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Ratio - 1);
  localparam int RestWidth = DataWidth - SliceWidth;

  if ((DataWidth % SliceWidth) != 0 || Ratio < 2) begin : gBadParams
    $error("cdc_fifo_slice_unpacker: DataWidth must be a multiple of SliceWidth with Ratio >= 2");
  end

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                stateQ;
  logic [IdxWidth-1:0]   idxQ;
  logic [RestWidth-1:0]  restQ;  // slices not yet presented, next one in the low bits
  logic                  outValidQ;
  logic [SliceWidth-1:0] outDataQ;
  logic                  outLastQ;

  logic accept;
  logic finalSlice;
  logic load;

  // Handshake: a slice transfers on any edge where Out_Valid_DB & Out_Ready_DB;
  // upstream word is consumed by the In_Deq_DB pulse, which only fires with In_Valid_DB.
  assign accept     = outValidQ & Out_Ready_DB;
  assign finalSlice = accept & (idxQ == LastIdx);
  assign load       = In_Valid_DB & ((stateQ == EMPTY) | finalSlice);

  assign In_Deq_DB    = rst_n & load;
  assign Out_Valid_DB = outValidQ;
  assign Out_Data_DB  = outDataQ;
  assign Out_Last_DB  = outLastQ;
  assign Busy_DB      = (stateQ == ACTIVE);

  always_ff @(posedge clk_DB or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= EMPTY;
      idxQ      <= '0;
      restQ     <= '0;
      outValidQ <= 1'b0;
      outDataQ  <= '0;
      outLastQ  <= 1'b0;
    end else if (load) begin
      stateQ    <= ACTIVE;
      idxQ      <= '0;
      restQ     <= In_Data_DB[DataWidth-1:SliceWidth];
      outValidQ <= 1'b1;
      outDataQ  <= In_Data_DB[SliceWidth-1:0];
      outLastQ  <= 1'b0;
    end else if (finalSlice) begin
      // Data deliberately left at the last slice; only valid/last drop.
      stateQ    <= EMPTY;
      outValidQ <= 1'b0;
      outLastQ  <= 1'b0;
    end else if (accept) begin
      idxQ     <= idxQ + 1'b1;
      restQ    <= restQ >> SliceWidth;
      outDataQ <= restQ[SliceWidth-1:0];
      outLastQ <= ((idxQ + 1'b1) == LastIdx);
    end
  end

endmodule

// File: tb/tb_cdc_fifo_slice_unpacker.sv
// Bench for cdc_fifo_slice_unpacker: directed scenarios plus a randomized run, both
// checked against a slice-queue model of the expected output stream.
module tb_cdc_fifo_slice_unpacker;

  localparam int DW    = 32;
  localparam int SW    = 8;
  localparam int RATIO = DW / SW;

  logic clk_DB = 1'b0;
  always #5 clk_DB = ~clk_DB;

  logic          rst_n    = 1'b1;
  logic          inValid  = 1'b0;
  logic [DW-1:0] inData   = '0;
  logic          deq;
  logic          outValid;
  logic [SW-1:0] outData;
  logic          outLast;
  logic          outReady = 1'b0;
  logic          busy;

  logic          inValid16  = 1'b0;
  logic [31:0]   inData16   = '0;
  logic          deq16;
  logic          outValid16;
  logic [15:0]   outData16;
  logic          outLast16;
  logic          outReady16 = 1'b0;
  logic          busy16;

  int nTests = 0;
  int nFail  = 0;

  // Each entry is {last, slice}; front is the slice the DUT must be showing.
  logic [SW:0] exp_q[$];
  logic        expDeq;
  logic        sawDeq = 1'b0;

  cdc_fifo_slice_unpacker #(.DataWidth(DW), .SliceWidth(SW)) dut (
    .clk_DB(clk_DB), .rst_n(rst_n),
    .In_Valid_DB(inValid), .In_Data_DB(inData), .In_Deq_DB(deq),
    .Out_Valid_DB(outValid), .Out_Data_DB(outData), .Out_Last_DB(outLast),
    .Out_Ready_DB(outReady), .Busy_DB(busy)
  );

  cdc_fifo_slice_unpacker #(.DataWidth(32), .SliceWidth(16)) dut16 (
    .clk_DB(clk_DB), .rst_n(rst_n),
    .In_Valid_DB(inValid16), .In_Data_DB(inData16), .In_Deq_DB(deq16),
    .Out_Valid_DB(outValid16), .Out_Data_DB(outData16), .Out_Last_DB(outLast16),
    .Out_Ready_DB(outReady16), .Busy_DB(busy16)
  );

  // Scoreboard: a word may be consumed only when every queued slice is gone by the
  // end of this cycle; a consumed word expands into RATIO slices, LS first.
  always @(negedge clk_DB) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      expDeq = inValid && (exp_q.size() == 0 || (exp_q.size() == 1 && outReady));
      nTests++;
      if (deq !== expDeq) begin
        nFail++;
        $display("FAIL sb_deq t=%0t: got %b expected %b", $time, deq, expDeq);
      end
      nTests++;
      if (busy !== outValid) begin
        nFail++;
        $display("FAIL sb_busy t=%0t: got %b expected %b", $time, busy, outValid);
      end
      if (exp_q.size() != 0) begin
        nTests++;
        if ({outValid, outLast, outData} !== {1'b1, exp_q[0]}) begin
          nFail++;
          $display("FAIL sb_slice t=%0t: got v/l/d %b/%b/%h expected 1/%b/%h",
                   $time, outValid, outLast, outData, exp_q[0][SW], exp_q[0][SW-1:0]);
        end
        if (outReady) void'(exp_q.pop_front());
      end else begin
        nTests++;
        if (outValid !== 1'b0) begin
          nFail++;
          $display("FAIL sb_idle_valid t=%0t: got %b expected 0", $time, outValid);
        end
      end
      if (deq === 1'b1)
        for (int i = 0; i < RATIO; i++) exp_q.push_back({i == RATIO - 1, inData[i*SW +: SW]});
    end
  end

  task automatic nextCycle();
    @(posedge clk_DB);
    #1;
  endtask

  task automatic sampleNow();
    @(negedge clk_DB);
  endtask

  task automatic test_reset();
    #2;
    rst_n    = 1'b0;
    inValid  = 1'b1;
    inData   = $urandom;
    outReady = 1'b1;
    #10;
    nTests++;
    if ({deq, outValid, outData, outLast, busy} !== '0) begin
      nFail++;
      $display("FAIL reset_outputs: got deq/v/d/l/b %b/%b/%h/%b/%b expected all 0",
               deq, outValid, outData, outLast, busy);
    end
    nextCycle();
    inValid = 1'b0;
    rst_n   = 1'b1;
    sampleNow();
    nTests++;
    if ({deq, outValid, outData, outLast, busy} !== '0) begin
      nFail++;
      $display("FAIL reset_release: got deq/v/d/l/b %b/%b/%h/%b/%b expected all 0",
               deq, outValid, outData, outLast, busy);
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      nextCycle();
      inValid  = 1'b0;
      inData   = $urandom;
      outReady = 1'($urandom_range(0, 1));
      sampleNow();
      nTests++;
      if ({deq, outValid, busy} !== 3'b000) begin
        nFail++;
        $display("FAIL idle c%0d: got deq/v/b %b/%b/%b expected 0/0/0", c, deq, outValid, busy);
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] w = 32'hA1B2C3D4;
    nextCycle();
    inValid = 1'b1; inData = w; outReady = 1'b1;
    sampleNow();
    nTests++;
    if (deq !== 1'b1) begin nFail++; $display("FAIL single_deq c0: got %b expected 1", deq); end
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      inValid = 1'b0; inData = $urandom;
      sampleNow();
      nTests++;
      if (c <= 4) begin
        if ({outValid, outLast, outData} !== {1'b1, c == 4, 8'(w >> (8 * (c - 1)))}) begin
          nFail++;
          $display("FAIL single_slice c%0d: got v/l/d %b/%b/%h expected 1/%b/%h",
                   c, outValid, outLast, outData, c == 4, 8'(w >> (8 * (c - 1))));
        end
      end else if (outValid !== 1'b0) begin
        nFail++;
        $display("FAIL single_end c5: got valid %b expected 0", outValid);
      end
      nTests++;
      if (deq !== 1'b0) begin nFail++; $display("FAIL single_nodeq c%0d: got %b expected 0", c, deq); end
    end
  endtask

  task automatic test_back_to_back();
    nextCycle();
    inValid = 1'b1; inData = 32'h03020100; outReady = 1'b1;
    sampleNow();
    nTests++;
    if (deq !== 1'b1) begin nFail++; $display("FAIL b2b_deq c0: got %b expected 1", deq); end
    for (int c = 1; c <= 9; c++) begin
      nextCycle();
      if (c == 1) inData = 32'h07060504;
      if (c == 5) inValid = 1'b0;
      sampleNow();
      nTests++;
      if (deq !== (c == 4)) begin
        nFail++;
        $display("FAIL b2b_deq c%0d: got %b expected %b", c, deq, c == 4);
      end
      nTests++;
      if (c <= 8) begin
        if ({outValid, outLast, outData} !== {1'b1, c == 4 || c == 8, 8'(c - 1)}) begin
          nFail++;
          $display("FAIL b2b_slice c%0d: got v/l/d %b/%b/%h expected 1/%b/%h",
                   c, outValid, outLast, outData, c == 4 || c == 8, 8'(c - 1));
        end
      end else if (outValid !== 1'b0) begin
        nFail++;
        $display("FAIL b2b_end c9: got valid %b expected 0", outValid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w0 = 32'h11223344;
    logic [31:0] w1 = 32'h55667788;
    logic [7:0]  got[$];
    logic [7:0]  want;
    nextCycle();
    inValid = 1'b1; inData = w0; outReady = 1'b1;
    sampleNow();
    for (int c = 1; c <= 12; c++) begin
      nextCycle();
      if (c == 1) inData = w1;
      if (c == 8) inValid = 1'b0;
      outReady = !(c >= 2 && c <= 4);
      sampleNow();
      nTests++;
      if (deq !== (c == 7)) begin
        nFail++;
        $display("FAIL bp_deq c%0d: got %b expected %b", c, deq, c == 7);
      end
      if (c >= 2 && c <= 4) begin
        nTests++;
        if ({outValid, outData} !== {1'b1, 8'h33}) begin
          nFail++;
          $display("FAIL bp_hold c%0d: got v/d %b/%h expected 1/33", c, outValid, outData);
        end
      end
      if (outValid && outReady) got.push_back(outData);
    end
    nTests++;
    if (got.size() != 8) begin
      nFail++;
      $display("FAIL bp_count: got %0d slices expected 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        want = 8'(((i < 4) ? w0 : w1) >> (8 * (i % 4)));
        nTests++;
        if (got[i] !== want) begin
          nFail++;
          $display("FAIL bp_order #%0d: got %h expected %h", i, got[i], want);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w = 32'hCAFEF00D;
    nextCycle();
    inValid = 1'b1; inData = 32'hDEADBEEF; outReady = 1'b1;
    sampleNow();
    nextCycle();
    inValid = 1'b0;
    sampleNow();
    nextCycle();
    sampleNow();
    nTests++;
    if (outData !== 8'hBE) begin nFail++; $display("FAIL arst_pre: got %h expected be", outData); end
    #2;
    rst_n = 1'b0; inValid = 1'b1; inData = w;
    #1;
    nTests++;
    if ({deq, outValid, outData, outLast, busy} !== '0) begin
      nFail++;
      $display("FAIL arst_clear: got deq/v/d/l/b %b/%b/%h/%b/%b expected all 0",
               deq, outValid, outData, outLast, busy);
    end
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    sampleNow();
    nTests++;
    if (deq !== 1'b1) begin nFail++; $display("FAIL arst_deq: got %b expected 1", deq); end
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      inValid = 1'b0;
      sampleNow();
      nTests++;
      if (c <= 4) begin
        if ({outValid, outLast, outData} !== {1'b1, c == 4, 8'(w >> (8 * (c - 1)))}) begin
          nFail++;
          $display("FAIL arst_slice c%0d: got v/l/d %b/%b/%h expected 1/%b/%h",
                   c, outValid, outLast, outData, c == 4, 8'(w >> (8 * (c - 1))));
        end
      end else if (outValid !== 1'b0) begin
        nFail++;
        $display("FAIL arst_end: got valid %b expected 0", outValid);
      end
    end
  endtask

  task automatic test_slice16();
    logic [31:0] w = 32'h89ABCDEF;
    nextCycle();
    inValid16 = 1'b1; inData16 = w; outReady16 = 1'b1;
    sampleNow();
    nTests++;
    if (deq16 !== 1'b1) begin nFail++; $display("FAIL s16_deq: got %b expected 1", deq16); end
    for (int c = 1; c <= 3; c++) begin
      nextCycle();
      inValid16 = 1'b0;
      sampleNow();
      nTests++;
      if (c <= 2) begin
        if ({outValid16, outLast16, outData16} !== {1'b1, c == 2, 16'(w >> (16 * (c - 1)))}) begin
          nFail++;
          $display("FAIL s16_slice c%0d: got v/l/d %b/%b/%h expected 1/%b/%h",
                   c, outValid16, outLast16, outData16, c == 2, 16'(w >> (16 * (c - 1))));
        end
      end else if ({outValid16, busy16} !== 2'b00) begin
        nFail++;
        $display("FAIL s16_end: got v/b %b/%b expected 0/0", outValid16, busy16);
      end
    end
  endtask

  task automatic test_random();
    bit drained = 1'b0;
    sawDeq = 1'b0;
    for (int c = 0; c < 800; c++) begin
      nextCycle();
      if (sawDeq) begin
        inValid = ($urandom_range(0, 3) != 0);
        inData  = $urandom;
      end else if (!inValid) begin
        inValid = ($urandom_range(0, 2) == 0);
        inData  = $urandom;
      end
      outReady = ($urandom_range(0, 3) != 0);
      sampleNow();
      sawDeq = deq;
    end
    for (int c = 0; c < 40 && !drained; c++) begin
      nextCycle();
      inValid = 1'b0; outReady = 1'b1;
      sampleNow();
      drained = (exp_q.size() == 0) && !outValid;
    end
    nTests++;
    if (!drained) begin
      nFail++;
      $display("FAIL rand_drain: got %0d slices pending, valid %b expected 0 and 0", exp_q.size(), outValid);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_slice16();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
